// File: rtl/lfsr_share_arbiter.sv
// Round-robin arbiter handing out words from one shared Fibonacci LFSR.
// The LFSR advances only on a grant, so the sequence depends only on the request pattern.
module lfsr_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BITWIDTH = 10,
  parameter logic [BITWIDTH-1:0] TAP = 10'b0100010001,
  parameter logic [BITWIDTH-1:0] SEED = 10'b0000000001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant,
  output logic [BITWIDTH-1:0] rand_data,
  input  logic                reseed_valid,
  input  logic [BITWIDTH-1:0] reseed_value,
  output logic                busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RESEED = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [BITWIDTH-1:0] lfsr_r;
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [NUM_REQ-1:0]  grant_r;
  logic [BITWIDTH-1:0] rand_r;
  logic                busy_r;

  logic [NUM_REQ-1:0]  ereq_s;
  logic                win_found_s;
  logic [PTR_W-1:0]    win_idx_s;
  logic [NUM_REQ-1:0]  win_onehot_s;
  logic [PTR_W-1:0]    rr_ptr_nxt_s;

  function automatic logic parity_f(input logic [BITWIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic [BITWIDTH-1:0] lfsr_step_f(input logic [BITWIDTH-1:0] v);
    return {parity_f(v & TAP), v[BITWIDTH-1:1]};
  endfunction

  function automatic int wrap_f(input int a);
    if (a >= NUM_REQ) begin
      return a - NUM_REQ;
    end else begin
      return a;
    end
  endfunction

  // Round-robin winner search over requests, masking the requester granted last cycle.
  always_comb begin
    ereq_s       = req & ~grant_r;
    win_found_s  = 1'b0;
    win_idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found_s && ereq_s[PTR_W'(wrap_f(int'(rr_ptr_r) + k))]) begin
        win_found_s = 1'b1;
        win_idx_s   = PTR_W'(wrap_f(int'(rr_ptr_r) + k));
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_onehot_s = NUM_REQ'(1) << win_idx_s;
    if (win_idx_s == PTR_W'(NUM_REQ - 1)) begin
      rr_ptr_nxt_s = '0;
    end else begin
      rr_ptr_nxt_s = win_idx_s + 1'b1;
    end
  end

  // Next-state decision; a pending reseed always takes priority over requests.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE, GRANT, RESEED: begin
        if (reseed_valid) begin
          state_nxt_s = RESEED;
        end else if (win_found_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, LFSR and output registers; the action of a state happens on the edge that enters it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      lfsr_r   <= SEED;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      rand_r   <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      case (state_nxt_s)
        GRANT: begin
          grant_r  <= win_onehot_s;
          rand_r   <= lfsr_r;
          lfsr_r   <= lfsr_step_f(lfsr_r);
          rr_ptr_r <= rr_ptr_nxt_s;
        end
        RESEED: begin
          grant_r <= '0;
          rand_r  <= '0;
          // An all-zero seed would lock the LFSR, so fall back to SEED.
          lfsr_r  <= (reseed_value == '0) ? SEED : reseed_value;
        end
        default: begin
          grant_r <= '0;
          rand_r  <= '0;
        end
      endcase
    end
  end

  assign grant     = grant_r;
  assign rand_data = rand_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected grants, a negedge monitor pops and compares.
module tb_lfsr_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [9:0] rand_data;
  logic       reseed_valid;
  logic [9:0] reseed_value;
  logic       busy;

  typedef struct {
    logic [3:0] g;
    logic [9:0] d;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  lfsr_share_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .rand_data    (rand_data),
    .reseed_valid (reseed_valid),
    .reseed_value (reseed_value),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [9:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented grant must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (grant !== 4'b0000) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", {28'd0, grant}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("grant", {28'd0, grant}, {28'd0, e.g});
          chk("rand_data", {22'd0, rand_data}, {22'd0, e.d});
          chk("busy_on_grant", {31'd0, busy}, 32'd1);
        end
      end else begin
        chk("rand_zero_no_grant", {22'd0, rand_data}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    reseed_valid = 1'b0;
    reseed_value = 10'h000;
    #2 rst = 1'b1;
    #2;
    chk("reset_grant", {28'd0, grant}, 32'd0);
    chk("reset_rand", {22'd0, rand_data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single requester twice, then two others: 0x001, 0x200, 0x100, 0x280.
    req = 4'b0001; push(4'b0001, 10'h001); step(); req = 4'b0000; step();
    req = 4'b0001; push(4'b0001, 10'h200); step(); req = 4'b0000; step();
    req = 4'b0100; push(4'b0100, 10'h100); step(); req = 4'b0000; step();
    req = 4'b0010; push(4'b0010, 10'h280); step(); req = 4'b0000; step();
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // All requesting from reset: rotate 0,1,2,3,0 back-to-back.
    rst = 1'b1; #2 rst = 1'b0;
    req = 4'b1111;
    push(4'b0001, 10'h001); push(4'b0010, 10'h200); push(4'b0100, 10'h100);
    push(4'b1000, 10'h280); push(4'b0001, 10'h140);
    repeat (5) begin
      step();
      chk("busy_stream", {31'd0, busy}, 32'd1);
    end
    req = 4'b0000; step();
    chk("busy_after_stream", {31'd0, busy}, 32'd0);
    req = 4'b1000; push(4'b1000, 10'h2A0); step(); req = 4'b0000; step();

    // Reseed wins over simultaneous requests; next grant delivers the new seed.
    req = 4'b1111; reseed_valid = 1'b1; reseed_value = 10'h155;
    push(4'b0001, 10'h155);
    step();
    chk("reseed_grant_zero", {28'd0, grant}, 32'd0);
    chk("reseed_busy", {31'd0, busy}, 32'd1);
    reseed_valid = 1'b0;
    step(); req = 4'b0000; step();

    // Zero reseed substitutes SEED.
    reseed_valid = 1'b1; reseed_value = 10'h000; step();
    reseed_valid = 1'b0; step();
    req = 4'b0010; push(4'b0010, 10'h001); step(); req = 4'b0000; step();

    // Reset in the middle of a grant stream.
    req = 4'b1111;
    push(4'b0100, 10'h200); push(4'b1000, 10'h100);
    step(); step();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_grant", {28'd0, grant}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rand", {22'd0, rand_data}, 32'd0);
    req = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;
    req = 4'b0001; push(4'b0001, 10'h001); step(); req = 4'b0000; step(); step();

    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
